// File: rtl/lpif_txrx_x2_h1_master_buf_if.sv
// LPIF x2/h1 master-side channel bundle: downstream LPIF bus, TX/RX FIFO word
// ports and the registered upstream LPIF bus.
interface lpif_txrx_x2_h1_master_buf_if;
    logic [3:0]   dstrm_state;
    logic [1:0]   dstrm_protid;
    logic [127:0] dstrm_data;
    logic         dstrm_dvalid;
    logic [15:0]  dstrm_crc;
    logic         dstrm_crc_valid;
    logic         dstrm_valid;

    logic [152:0] txfifo_downstream_data;
    logic         txfifo_downstream_valid;
    logic         txfifo_downstream_ready;

    logic [152:0] rxfifo_upstream_data;
    logic         rxfifo_upstream_valid;

    logic [3:0]   ustrm_state;
    logic [1:0]   ustrm_protid;
    logic [127:0] ustrm_data;
    logic         ustrm_dvalid;
    logic [15:0]  ustrm_crc;
    logic         ustrm_crc_valid;
    logic         ustrm_valid;

    modport master (
        input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
               dstrm_crc, dstrm_crc_valid, dstrm_valid,
               txfifo_downstream_ready,
               rxfifo_upstream_data, rxfifo_upstream_valid,
        output txfifo_downstream_data, txfifo_downstream_valid,
               ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
               ustrm_crc, ustrm_crc_valid, ustrm_valid
    );

    modport slave (
        output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid,
               dstrm_crc, dstrm_crc_valid, dstrm_valid,
               txfifo_downstream_ready,
               rxfifo_upstream_data, rxfifo_upstream_valid,
        input  txfifo_downstream_data, txfifo_downstream_valid,
               ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid,
               ustrm_crc, ustrm_crc_valid, ustrm_valid
    );
endinterface

// File: rtl/lpif_txrx_x2_h1_master_buf.sv
// Master-side LPIF x2/h1 logic-link end: packs downstream LPIF into a small
// TX buffer with drop accounting, and registers unpacked upstream words.
module lpif_txrx_x2_h1_master_buf #(
    parameter int TX_DEPTH  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                      clk_wr,
    input  logic                      rst_wr,
    lpif_txrx_x2_h1_master_buf_if.master lpif,
    output logic [$clog2(TX_DEPTH):0] tx_level,
    output logic                      tx_overflow,
    output logic [CNT_WIDTH-1:0]      tx_drop_cnt
);
    localparam int AW = $clog2(TX_DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic         valid;
        logic         crc_valid;
        logic [15:0]  crc;
        logic         dvalid;
        logic [127:0] data;
        logic [1:0]   protid;
        logic [3:0]   state;
    } lpif_word_t;

    lpif_word_t        mem [TX_DEPTH];
    lpif_word_t        push_word;
    lpif_word_t        rx_word;
    lpif_word_t        us_q;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [3:0]        last_state;
    logic              push_req, deq, full, accept, reject, tx_valid;

    always_comb begin
        push_word           = '0;
        push_word.state     = lpif.dstrm_state;
        push_word.protid    = lpif.dstrm_protid;
        push_word.data      = lpif.dstrm_data;
        push_word.dvalid    = lpif.dstrm_dvalid;
        push_word.crc       = lpif.dstrm_crc;
        push_word.crc_valid = lpif.dstrm_crc_valid;
        push_word.valid     = lpif.dstrm_valid;
    end

    // A bare state transition is itself worth a word so the far side tracks it.
    assign push_req = lpif.dstrm_valid | (lpif.dstrm_state != last_state);
    assign tx_valid = (tx_level != '0);
    assign deq      = tx_valid & lpif.txfifo_downstream_ready;
    assign full     = (tx_level == LW'(TX_DEPTH));
    assign accept   = push_req & (~full | deq);
    assign reject   = push_req & full & ~deq;

    always_ff @(posedge clk_wr) begin
        if (!rst_wr && accept) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_level    <= '0;
            last_state  <= '0;
            tx_overflow <= 1'b0;
            tx_drop_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr     <= wr_ptr + 1'b1;
                last_state <= lpif.dstrm_state;
            end
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, deq})
                2'b10:   tx_level <= tx_level + 1'b1;
                2'b01:   tx_level <= tx_level - 1'b1;
                default: tx_level <= tx_level;
            endcase
            // Dropped words leave last_state untouched so a state change retries.
            if (reject) begin
                tx_overflow <= 1'b1;
                if (tx_drop_cnt != '1) tx_drop_cnt <= tx_drop_cnt + 1'b1;
            end
        end
    end

    // Gate stale memory so the port reads zero whenever the buffer is empty.
    assign lpif.txfifo_downstream_valid = tx_valid;
    assign lpif.txfifo_downstream_data  = tx_valid ? mem[rd_ptr] : '0;

    assign rx_word = lpif.rxfifo_upstream_data;

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            us_q <= '0;
        end else if (lpif.rxfifo_upstream_valid) begin
            us_q <= rx_word;
        end else begin
            us_q.dvalid    <= 1'b0;
            us_q.crc_valid <= 1'b0;
            us_q.valid     <= 1'b0;
        end
    end

    assign lpif.ustrm_state     = us_q.state;
    assign lpif.ustrm_protid    = us_q.protid;
    assign lpif.ustrm_data      = us_q.data;
    assign lpif.ustrm_dvalid    = us_q.dvalid;
    assign lpif.ustrm_crc       = us_q.crc;
    assign lpif.ustrm_crc_valid = us_q.crc_valid;
    assign lpif.ustrm_valid     = us_q.valid;
endmodule

// File: tb/tb_lpif_txrx_x2_h1_master_buf.sv
// Scoreboard bench for lpif_txrx_x2_h1_master_buf: expected TX words are queued
// as stimulus is driven and compared as the DUT dequeues them.
module tb_lpif_txrx_x2_h1_master_buf;
    logic       clk_wr = 1'b0;
    logic       rst_wr;
    logic [2:0] tx_level;
    logic       tx_overflow;
    logic [7:0] tx_drop_cnt;
    int         checks = 0;
    int         errors = 0;
    logic [152:0] exp_q [$];

    always #5 clk_wr = ~clk_wr;

    lpif_txrx_x2_h1_master_buf_if bus ();

    lpif_txrx_x2_h1_master_buf #(.TX_DEPTH(4), .CNT_WIDTH(8)) u_dut (
        .clk_wr      (clk_wr),
        .rst_wr      (rst_wr),
        .lpif        (bus),
        .tx_level    (tx_level),
        .tx_overflow (tx_overflow),
        .tx_drop_cnt (tx_drop_cnt)
    );

    function automatic logic [152:0] mk(input logic [3:0] st, input logic [1:0] pid,
                                        input logic [127:0] d, input logic dv,
                                        input logic [15:0] crc, input logic cv,
                                        input logic v);
        return {v, cv, crc, dv, d, pid, st};
    endfunction

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic drive_dstrm(input logic [152:0] w);
        bus.dstrm_state     = w[3:0];
        bus.dstrm_protid    = w[5:4];
        bus.dstrm_data      = w[133:6];
        bus.dstrm_dvalid    = w[134];
        bus.dstrm_crc       = w[150:135];
        bus.dstrm_crc_valid = w[151];
        bus.dstrm_valid     = w[152];
    endtask

    // Scoreboard consumer: a word is taken on the next edge when valid & ready.
    always @(negedge clk_wr) begin
        if (!rst_wr && bus.txfifo_downstream_valid && bus.txfifo_downstream_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_word unexpected: got %h, required none", bus.txfifo_downstream_data);
            end else begin
                logic [152:0] e;
                e = exp_q.pop_front();
                if (bus.txfifo_downstream_data !== e) begin
                    errors++;
                    $display("FAIL tx_word: got %h, required %h", bus.txfifo_downstream_data, e);
                end
            end
        end
    end

    task automatic drain(input string name);
        bus.txfifo_downstream_ready = 1'b1;
        for (int i = 0; i < 40 && tx_level != 0; i++) tick();
        checks++;
        if (tx_level !== 3'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: level %0d pending %0d, required 0 and 0", name, tx_level, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_wr = 1'b1;
        drive_dstrm('0);
        bus.txfifo_downstream_ready = 1'b0;
        bus.rxfifo_upstream_data    = '0;
        bus.rxfifo_upstream_valid   = 1'b0;
        tick(); tick();
        rst_wr = 1'b0;
        checks++;
        if ({tx_level, tx_overflow, tx_drop_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_status: got lvl=%0d ovf=%0b drop=%0d, required 0", tx_level, tx_overflow, tx_drop_cnt);
        end
        checks++;
        if ({bus.txfifo_downstream_valid, bus.txfifo_downstream_data} !== '0) begin
            errors++;
            $display("FAIL reset_tx: got v=%0b d=%h, required 0", bus.txfifo_downstream_valid, bus.txfifo_downstream_data);
        end
        checks++;
        if (bus.ustrm_valid !== 1'b0 || bus.ustrm_data !== '0) begin
            errors++;
            $display("FAIL reset_ustrm: got v=%0b d=%h, required 0", bus.ustrm_valid, bus.ustrm_data);
        end
    endtask

    task automatic test_single();
        logic [152:0] w;
        w = mk(4'h0, 2'd1, {16{8'hA5}}, 1'b1, 16'hBEEF, 1'b1, 1'b1);
        bus.txfifo_downstream_ready = 1'b1;
        drive_dstrm(w);
        exp_q.push_back(w);
        tick();
        w[152] = 1'b0;
        drive_dstrm(w);
        checks++;
        if (bus.txfifo_downstream_valid !== 1'b1 || bus.txfifo_downstream_data[133:6] !== {16{8'hA5}}
            || bus.txfifo_downstream_data[152] !== 1'b1) begin
            errors++;
            $display("FAIL single_present: got v=%0b d=%h, required v=1 A5 payload valid bit 1",
                     bus.txfifo_downstream_valid, bus.txfifo_downstream_data);
        end
        tick();
        checks++;
        if (tx_level !== 3'd0 || bus.txfifo_downstream_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got lvl=%0d v=%0b, required 0 0", tx_level, bus.txfifo_downstream_valid);
        end
    endtask

    task automatic test_state_only();
        logic [152:0] w;
        w = mk(4'h3, 2'd0, 128'h77, 1'b0, 16'h0, 1'b0, 1'b0);
        bus.txfifo_downstream_ready = 1'b0;
        drive_dstrm(w);
        exp_q.push_back(w);
        tick();
        checks++;
        if (tx_level !== 3'd1 || bus.txfifo_downstream_data[3:0] !== 4'h3 || bus.txfifo_downstream_data[152] !== 1'b0) begin
            errors++;
            $display("FAIL state_only_push: got lvl=%0d d=%h, required lvl=1 state=3 valid=0",
                     tx_level, bus.txfifo_downstream_data);
        end
        tick(); tick(); tick();
        checks++;
        if (tx_level !== 3'd1) begin
            errors++;
            $display("FAIL state_only_repeat: got lvl=%0d, required 1", tx_level);
        end
        drain("state_only");
        bus.txfifo_downstream_ready = 1'b0;
    endtask

    task automatic test_overflow();
        bus.txfifo_downstream_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [152:0] w;
            w = mk(4'h3, 2'd2, 128'(i + 1), 1'b1, 16'(i), 1'b1, 1'b1);
            drive_dstrm(w);
            if (i < 4) exp_q.push_back(w);
            tick();
        end
        drive_dstrm(mk(4'h3, 2'd0, 128'h0, 1'b0, 16'h0, 1'b0, 1'b0));
        checks++;
        if (tx_level !== 3'd4 || tx_overflow !== 1'b1 || tx_drop_cnt !== 8'd2) begin
            errors++;
            $display("FAIL overflow: got lvl=%0d ovf=%0b drop=%0d, required 4 1 2", tx_level, tx_overflow, tx_drop_cnt);
        end
    endtask

    task automatic test_full_push_deq();
        logic [152:0] w;
        w = mk(4'h3, 2'd3, 128'd100, 1'b1, 16'h1111, 1'b0, 1'b1);
        bus.txfifo_downstream_ready = 1'b1;
        drive_dstrm(w);
        exp_q.push_back(w);
        tick();
        drive_dstrm(mk(4'h3, 2'd0, 128'h0, 1'b0, 16'h0, 1'b0, 1'b0));
        checks++;
        if (tx_level !== 3'd4 || tx_drop_cnt !== 8'd2 || tx_overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_push_deq: got lvl=%0d drop=%0d ovf=%0b, required 4 2 1", tx_level, tx_drop_cnt, tx_overflow);
        end
        drain("full_push_deq");
        bus.txfifo_downstream_ready = 1'b0;
    endtask

    task automatic test_saturate();
        bus.txfifo_downstream_ready = 1'b0;
        for (int i = 0; i < 264; i++) begin
            logic [152:0] w;
            w = mk(4'h3, 2'd1, 128'(32'hC000 + i), 1'b0, 16'h0, 1'b0, 1'b1);
            drive_dstrm(w);
            if (i < 4) exp_q.push_back(w);
            tick();
        end
        drive_dstrm(mk(4'h3, 2'd0, 128'h0, 1'b0, 16'h0, 1'b0, 1'b0));
        checks++;
        if (tx_drop_cnt !== 8'hFF || tx_level !== 3'd4) begin
            errors++;
            $display("FAIL drop_saturate: got drop=%0d lvl=%0d, required 255 4", tx_drop_cnt, tx_level);
        end
        drain("saturate");
        bus.txfifo_downstream_ready = 1'b0;
    endtask

    task automatic test_upstream();
        bus.rxfifo_upstream_data  = mk(4'h1, 2'd2, 128'h1234, 1'b1, 16'hCAFE, 1'b1, 1'b1);
        bus.rxfifo_upstream_valid = 1'b1;
        tick();
        bus.rxfifo_upstream_data  = '1;
        bus.rxfifo_upstream_valid = 1'b0;
        checks++;
        if ({bus.ustrm_valid, bus.ustrm_crc_valid, bus.ustrm_crc, bus.ustrm_dvalid, bus.ustrm_data,
             bus.ustrm_protid, bus.ustrm_state} !== {1'b1, 1'b1, 16'hCAFE, 1'b1, 128'h1234, 2'd2, 4'h1}) begin
            errors++;
            $display("FAIL upstream_load: got st=%h pid=%0d d=%h crc=%h v=%0b, required 1 2 1234 cafe 1",
                     bus.ustrm_state, bus.ustrm_protid, bus.ustrm_data, bus.ustrm_crc, bus.ustrm_valid);
        end
        tick();
        checks++;
        if (bus.ustrm_valid !== 1'b0 || bus.ustrm_dvalid !== 1'b0 || bus.ustrm_crc_valid !== 1'b0
            || bus.ustrm_data !== 128'h1234 || bus.ustrm_state !== 4'h1 || bus.ustrm_crc !== 16'hCAFE) begin
            errors++;
            $display("FAIL upstream_hold: got v=%0b dv=%0b cv=%0b d=%h st=%h, required 0 0 0 1234 1",
                     bus.ustrm_valid, bus.ustrm_dvalid, bus.ustrm_crc_valid, bus.ustrm_data, bus.ustrm_state);
        end
    endtask

    task automatic test_reset_mid();
        bus.txfifo_downstream_ready = 1'b0;
        bus.rxfifo_upstream_data    = mk(4'h5, 2'd1, 128'h55, 1'b1, 16'h5, 1'b1, 1'b1);
        bus.rxfifo_upstream_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [152:0] w;
            w = mk(4'h3, 2'd0, 128'(i + 7), 1'b0, 16'h0, 1'b0, 1'b1);
            drive_dstrm(w);
            exp_q.push_back(w);
            tick();
        end
        checks++;
        if (tx_level !== 3'd3 || bus.ustrm_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_setup: got lvl=%0d uv=%0b, required 3 1", tx_level, bus.ustrm_valid);
        end
        rst_wr = 1'b1;
        exp_q.delete();
        tick();
        rst_wr = 1'b0;
        drive_dstrm('0);
        bus.rxfifo_upstream_valid = 1'b0;
        checks++;
        if ({tx_level, bus.txfifo_downstream_valid, tx_overflow, tx_drop_cnt} !== '0
            || bus.txfifo_downstream_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_tx: got lvl=%0d v=%0b ovf=%0b drop=%0d, required 0",
                     tx_level, bus.txfifo_downstream_valid, tx_overflow, tx_drop_cnt);
        end
        checks++;
        if ({bus.ustrm_valid, bus.ustrm_crc_valid, bus.ustrm_crc, bus.ustrm_dvalid, bus.ustrm_data,
             bus.ustrm_protid, bus.ustrm_state} !== '0) begin
            errors++;
            $display("FAIL reset_mid_ustrm: got st=%h d=%h v=%0b, required 0", bus.ustrm_state, bus.ustrm_data, bus.ustrm_valid);
        end
        tick();
        checks++;
        if (tx_level !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_idle: got lvl=%0d, required 0", tx_level);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_state_only();
        test_overflow();
        test_full_push_deq();
        test_saturate();
        test_upstream();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lpif_txrx_x2_h1_master_buf.md
Name: lpif_txrx_x2_h1_master_buf

Overview:
- Master-side end of the LPIF x2/h1 logic-link channel.
- Downstream: packs the LPIF downstream bus into a 153-bit word and queues it toward the TX FIFO through a small buffer with valid/ready.
- Upstream: unpacks 153-bit words arriving from the RX FIFO into registered LPIF upstream signals.
- Sits between the LPIF adapter (master) and the AIB logic-link FIFOs.

Parameters:
- TX_DEPTH, 4, downstream buffer entries; power of 2, range 2..16.
- CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk_wr  in  1  sole clock.
- rst_wr  in  1  synchronous, active-high reset.
- dstrm_state  in  4  LPIF downstream state.
- dstrm_protid  in  2  protocol id.
- dstrm_data  in  128  payload.
- dstrm_dvalid  in  1  data valid.
- dstrm_crc  in  16  CRC.
- dstrm_crc_valid  in  1  CRC valid.
- dstrm_valid  in  1  flit valid.
- txfifo_downstream_data  out  153  packed word to TX FIFO.
- txfifo_downstream_valid  out  1  word available.
- txfifo_downstream_ready  in  1  TX FIFO accepts.
- rxfifo_upstream_data  in  153  packed word from RX FIFO.
- rxfifo_upstream_valid  in  1  RX word present.
- ustrm_state  out  4;  ustrm_protid  out  2;  ustrm_data  out  128;  ustrm_dvalid  out  1;  ustrm_crc  out  16;  ustrm_crc_valid  out  1;  ustrm_valid  out  1.
- tx_level  out  $clog2(TX_DEPTH)+1  current buffer occupancy.
- tx_overflow  out  1  sticky drop flag.
- tx_drop_cnt  out  CNT_WIDTH  saturating count of dropped words.

Behaviour:
- Packing, used in both directions:
  - [3:0] state, [5:4] protid, [133:6] data, [134] dvalid.
  - [150:135] crc, [151] crc_valid, [152] valid.
- Push request (push_req):
  - Asserted when dstrm_valid=1, or when dstrm_state != last_state.
  - last_state is an internal register, reset 4'h0.
  - A state change alone therefore generates a word (dstrm_valid=0, payload fields as presented).
- Dequeue (deq) = txfifo_downstream_valid & txfifo_downstream_ready.
- Push acceptance: accepted if tx_level < TX_DEPTH, or if deq occurs in the same cycle. Push and pop in the same cycle leave the level unchanged.
- On accept: word written at the write pointer; last_state <= dstrm_state.
- On reject (full and no deq):
  - Word is dropped; last_state is not updated, so a pending state change re-requests on the next cycle.
  - tx_overflow <= 1 (sticky until reset).
  - tx_drop_cnt increments, saturating at all-ones.
- TX output:
  - txfifo_downstream_valid = (tx_level != 0).
  - txfifo_downstream_data = entry at the read pointer.
  - A word pushed into an empty buffer in cycle N is presented in cycle N+1.
  - Data and valid hold stable until deq. Ordering is strict FIFO.
- Pointers wrap modulo TX_DEPTH.
- Upstream unpack (1-cycle latency):
  - When rxfifo_upstream_valid=1, all ustrm_* fields load from rxfifo_upstream_data.
  - When 0: ustrm_state, protid, data and crc hold their values; ustrm_dvalid, crc_valid and valid go to 0.
- Reset (synchronous, also mid-operation):
  - All outputs are 0 in the cycle after rst_wr is sampled high. This covers ustrm_*, txfifo_downstream_valid, txfifo_downstream_data, tx_level, tx_overflow and tx_drop_cnt.
  - Pointers and last_state clear; queued words are discarded.
  - Push and rx inputs are ignored while rst_wr=1.

Test Plan:
- Single flit, empty buffer, ready=1: dstrm_valid=1, data=128'hA5..A5 at cycle N → txfifo_downstream_valid=1 at N+1, bits[133:6]=A5..A5, bit152=1, tx_level returns to 0 at N+2.
- State-only change: dstrm_valid=0, state 0→3 → exactly one word pushed with [3:0]=4'h3 and bit152=0; no further words while state remains 3.
- Backpressure/overflow, TX_DEPTH=4, ready=0: 6 consecutive valid flits → tx_level=4, tx_overflow=1, tx_drop_cnt=2. Raising ready then drains the 4 words in push order.
- Full with simultaneous push and deq: tx_level=4, ready=1, push → push accepted, tx_level stays 4, tx_drop_cnt unchanged.
- Upstream: rx word with state=4'h1, data=128'h1234, valid bit=1 in cycle N → ustrm_* updated at N+1. Next cycle with rxfifo_upstream_valid=0 → ustrm_valid=0, ustrm_data still 128'h1234.
- Reset mid-operation: 3 words queued, then rst_wr pulsed for 1 cycle → next cycle tx_level=0, txfifo_downstream_valid=0, tx_overflow=0, tx_drop_cnt=0, ustrm_* all 0.
